// File: rtl/d_phy_receiver_lane.sv
// Single HS data lane receiver: DDR sampling, 0xB8 sync hunt at either bit phase,
// then one byte strobe every four clock_p cycles until reset or an invalid line sample.
module d_phy_receiver_lane (
   input  logic       clock_p,
   input  logic       reset,
   input  logic       clock_n,
   input  logic       data_p,
   input  logic       data_n,
   output logic [7:0] data,
   output logic       enable
);

   localparam logic [7:0] SyncByte = 8'hB8;

   typedef enum logic [0:0] {StIdle, StReceive} state_e;

   state_e      state_q, state_d;
   logic        f_q;
   logic [9:0]  w_q, w_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic [7:0]  data_d;
   logic        enable_d;
   logic        line_valid;
   logic        unused_clock_n;

   assign unused_clock_n = clock_n;

   // Falling-edge half of the DDR pair; shifted in together with the rising-edge sample.
   always_ff @(negedge clock_p) begin
      f_q <= data_p;
   end

   assign w_d        = {data_p, f_q, w_q[9:2]};
   assign line_valid = (data_p != data_n);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      data_d   = data;
      enable_d = 1'b0;
      if (!line_valid) begin
         state_d = StIdle;
         cnt_d   = 2'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d = 2'd0;
               if (w_d[9:2] == SyncByte) begin
                  state_d = StReceive;
                  phase_d = 1'b0;
               end else if (w_d[8:1] == SyncByte) begin
                  state_d = StReceive;
                  phase_d = 1'b1;
               end
            end
            StReceive: begin
               cnt_d = cnt_q + 2'd1;
               // Counter wrapping to zero marks eight fresh bits past the last boundary.
               if (cnt_q == 2'd3) begin
                  data_d   = phase_q ? w_d[8:1] : w_d[9:2];
                  enable_d = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clock_p) begin
      if (!reset) begin
         state_q <= StIdle;
         w_q     <= 10'd0;
         cnt_q   <= 2'd0;
         phase_q <= 1'b0;
         data    <= 8'h00;
         enable  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         data    <= data_d;
         enable  <= enable_d;
      end
   end

endmodule

// File: tb/tb_d_phy_receiver_lane.sv
// Directed bench for d_phy_receiver_lane: half-bit stimulus queue, strobe monitor on the
// falling edge, expected bytes and strobe cycle offsets computed by hand.
module tb_d_phy_receiver_lane;

   logic       clock_p = 1'b0;
   logic       clock_n;
   logic       reset;
   logic       data_p;
   logic       data_n;
   logic [7:0] data;
   logic       enable;

   d_phy_receiver_lane dut (
      .clock_p (clock_p),
      .reset   (reset),
      .clock_n (clock_n),
      .data_p  (data_p),
      .data_n  (data_n),
      .data    (data),
      .enable  (enable)
   );

   assign clock_n = ~clock_p;
   always #5 clock_p = ~clock_p;

   int         cyc = 0;
   int         base = 0;
   int         str_cyc[$];
   logic [7:0] str_dat[$];
   logic [1:0] bits_q[$];   // {data_p, data_n} per half-cycle
   int         n_checks = 0;
   int         n_fail = 0;

   always @(posedge clock_p) cyc <= cyc + 1;

   always @(negedge clock_p) begin
      if (enable === 1'b1) begin
         str_cyc.push_back(cyc);
         str_dat.push_back(data);
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic hb(input logic [1:0] pn);
      @(clock_p);
      #1;
      data_p = pn[1];
      data_n = pn[0];
   endtask

   task automatic q_bit(input logic b);
      bits_q.push_back({b, ~b});
   endtask

   task automatic q_zeros(input int n);
      for (int i = 0; i < n; i++) q_bit(1'b0);
   endtask

   task automatic q_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) q_bit(b[i]);
   endtask

   task automatic q_sync(input int lead);
      q_zeros(8 + lead);
      q_byte(8'hB8);
   endtask

   task automatic q_lp(input int n);
      for (int i = 0; i < n; i++) bits_q.push_back(2'b11);
   endtask

   // The first queued half-bit is sampled on a falling edge; base marks the reference cycle.
   task automatic play();
      @(negedge clock_p);
      #1;
      base = cyc;
      foreach (bits_q[i]) hb(bits_q[i]);
      bits_q.delete();
   endtask

   task automatic clear_strobes();
      str_cyc.delete();
      str_dat.delete();
   endtask

   task automatic check_two(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                            input int off0);
      check_eq({tag, "_count"}, str_cyc.size(), 2);
      if (str_cyc.size() == 2) begin
         check_eq({tag, "_byte0"}, str_dat[0], d0);
         check_eq({tag, "_byte1"}, str_dat[1], d1);
         check_eq({tag, "_lat0"}, str_cyc[0] - base, off0);
         check_eq({tag, "_gap"}, str_cyc[1] - str_cyc[0], 4);
      end
   endtask

   task automatic check_one(input string tag, input logic [7:0] d0, input int off0);
      check_eq({tag, "_count"}, str_cyc.size(), 1);
      if (str_cyc.size() == 1) begin
         check_eq({tag, "_byte"}, str_dat[0], d0);
         check_eq({tag, "_lat"}, str_cyc[0] - base, off0);
      end
   endtask

   initial begin
      logic b, prev1, prev2;
      reset  = 1'b0;
      data_p = 1'b0;
      data_n = 1'b1;
      repeat (3) @(posedge clock_p);
      #1;
      check_eq("reset_data", data, 8'h00);
      check_eq("reset_enable", enable, 0);
      reset = 1'b1;

      // Random bits never containing three zeros in a row cannot form the sync pattern.
      clear_strobes();
      for (int i = 0; i < 10; i++) q_bit(1'b1);
      prev1 = 1'b1;
      prev2 = 1'b1;
      for (int i = 0; i < 120; i++) begin
         b = 1'($urandom_range(0, 1));
         if (!prev1 && !prev2) b = 1'b1;
         q_bit(b);
         prev2 = prev1;
         prev1 = b;
      end
      q_lp(6);
      play();
      repeat (4) @(posedge clock_p);
      #1;
      check_eq("rand_count", str_cyc.size(), 0);
      check_eq("rand_data", data, 8'h00);

      // Phase 0: sync's last bit lands on a rising edge.
      clear_strobes();
      q_sync(0);
      q_byte(8'h2C);
      q_byte(8'h55);
      q_zeros(2);
      q_lp(6);
      play();
      repeat (6) @(posedge clock_p);
      check_two("ph0", 8'h2C, 8'h55, 13);

      // Phase 1: identical stream delayed by one half-cycle.
      clear_strobes();
      q_sync(1);
      q_byte(8'h2C);
      q_byte(8'h55);
      q_zeros(2);
      q_lp(6);
      play();
      repeat (6) @(posedge clock_p);
      check_two("ph1", 8'h2C, 8'h55, 14);

      // Sync value inside the payload is data, not a re-sync.
      clear_strobes();
      q_sync(0);
      q_byte(8'hB8);
      q_byte(8'h47);
      q_zeros(2);
      q_lp(6);
      play();
      repeat (6) @(posedge clock_p);
      check_two("pl_b8", 8'hB8, 8'h47, 13);

      // Reset two cycles into a byte.
      clear_strobes();
      q_sync(0);
      q_bit(1'b1);
      q_bit(1'b0);
      q_bit(1'b1);
      q_bit(1'b1);
      play();
      reset  = 1'b0;
      data_p = 1'b0;
      data_n = 1'b1;
      repeat (2) @(posedge clock_p);
      #1;
      check_eq("rst_mid_data", data, 8'h00);
      check_eq("rst_mid_enable", enable, 0);
      reset = 1'b1;
      repeat (8) @(posedge clock_p);
      check_eq("rst_mid_count", str_cyc.size(), 0);
      clear_strobes();
      q_sync(0);
      q_byte(8'hA5);
      q_zeros(2);
      q_lp(6);
      play();
      repeat (6) @(posedge clock_p);
      check_one("rst_resync", 8'hA5, 13);

      // One LP-11 rising-edge sample mid-stream drops back to sync hunt.
      clear_strobes();
      q_sync(0);
      q_byte(8'h2C);
      q_bit(1'b1);
      q_bit(1'b0);
      q_bit(1'b1);
      q_bit(1'b1);
      q_bit(1'b0);
      q_lp(1);
      q_zeros(24);
      q_lp(6);
      play();
      repeat (4) @(posedge clock_p);
      #1;
      check_one("lp11", 8'h2C, 13);
      check_eq("lp11_hold", data, 8'h2C);
      clear_strobes();
      q_sync(0);
      q_byte(8'h3C);
      q_zeros(2);
      q_lp(6);
      play();
      repeat (6) @(posedge clock_p);
      check_one("lp11_resync", 8'h3C, 13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
